vga_frame_fetch_sched: RTL and testbench
========================================

Name: vga_frame_fetch_sched

Overview:
- Read-side scheduler between the display timing generator and the SDRAM controller read port.
- Watches display vsync (frame sync) and the display read-FIFO fill level.
- Issues burst read requests with incrementing address and length so that exactly one frame of 16-bit pixels is fetched per display frame.
- Flushes the FIFO and restarts from the frame base at every vsync.

Parameters:
- ADDR_W, 24, SDRAM word address width.
- FRAME_BASE, 0, word address of pixel (0,0).
- FRAME_WORDS, 307200, words per frame (640x480); must be ≥1.
- BURST_LEN, 256, maximum burst length in words; 1..256.
- LVL_W, 10, width of the FIFO level input.
- FILL_THRESH, 512, a burst is requested only when the level is ≤ this value; FILL_THRESH+BURST_LEN must not exceed FIFO depth.

Ports:
- clk  in  1  system clock (display pixel clock domain)
- rst  in  1  asynchronous, active-high reset
- lcd_framesync  in  1  display vsync, active low
- fifo_wrusedw  in  LVL_W  read-FIFO fill level
- rd_req  out  1  burst read request; level, held until acknowledged
- rd_ack  in  1  one-cycle pulse: controller accepted the request
- rd_addr  out  ADDR_W  burst start word address
- rd_len  out  9  burst length in words, 1..256
- rd_done  in  1  one-cycle pulse: last word of the burst written to the FIFO
- fifo_aclr  out  1  FIFO clear
- frame_active  out  1  frame fetch in progress

Behaviour:
- Reset values: rd_req=0, rd_addr=FRAME_BASE, rd_len=0, fifo_aclr=0, frame_active=0, state=IDLE, words_left=0, restart_pend=0.
- Falling-edge detect: framesync_d is the registered copy of lcd_framesync. A falling edge (vs_fall) is framesync_d=1 && lcd_framesync=0. framesync_d resets to 1.
- IDLE: on vs_fall, go to FLUSH.
- FLUSH (2 cycles):
  - fifo_aclr=1 in both cycles.
  - Load rd_addr=FRAME_BASE, words_left=FRAME_WORDS.
  - Then go to CHECK and set frame_active=1.
- CHECK:
  - If words_left==0: frame_active=0, go to IDLE.
  - Else if fifo_wrusedw ≤ FILL_THRESH: rd_len=min(BURST_LEN, words_left), go to REQ.
  - Else stay in CHECK.
- REQ:
  - rd_req=1 (registered).
  - On rd_ack: rd_req=0 next cycle, go to XFER.
  - rd_addr and rd_len stay stable while rd_req=1.
- XFER: on rd_done, rd_addr += rd_len (modulo 2^ADDR_W), words_left -= rd_len, go to CHECK.
- Timing: with a low FIFO level, rd_req first rises 4 clocks after the cycle in which vs_fall is sampled (FLUSH, FLUSH, CHECK, REQ).
- vs_fall in CHECK: go to FLUSH immediately.
- vs_fall in REQ without rd_ack the same cycle: drop rd_req, go to FLUSH.
- vs_fall in REQ with rd_ack the same cycle: the ack wins; go to XFER with restart_pend=1.
- vs_fall in XFER: set restart_pend=1. The burst in flight is never aborted.
- rd_done with restart_pend=1: skip the address/count update, clear restart_pend, go to FLUSH.
- vs_fall during FLUSH: ignored.
- rd_ack outside REQ and rd_done outside XFER: ignored.
- Reset asserted mid-burst: all state returns to reset values asynchronously. Late rd_ack/rd_done after reset is released are ignored.
- Last burst of a frame is a short burst: FRAME_WORDS mod BURST_LEN words, if nonzero.

Optional Feature:
- Macro: VGA_FETCH_UNDERRUN_CNT_EN.
- With the macro defined:
  - Extra inputs: lcd_request (1 bit) and fifo_empty (1 bit).
  - Extra output: underrun_cnt (16 bits).
  - underrun_cnt increments on each clock with lcd_request && fifo_empty.
  - Saturates at 16'hFFFF.
  - Cleared by rst and on the first FLUSH cycle.
- Without the macro: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Bench parameters FRAME_WORDS=600, BURST_LEN=256, level input held at 0, rd_ack 2 cycles after rd_req, rd_done 10 cycles after ack. Drive vs_fall -> fifo_aclr high 2 cycles; bursts (addr,len) = (0,256), (256,256), (512,88); frame_active falls after the third rd_done; no further rd_req until the next vs_fall.
- Level held at FILL_THRESH+1 after FLUSH -> rd_req stays 0. Level then drops to FILL_THRESH -> rd_req rises exactly 1 cycle later, with len=256.
- vs_fall 3 cycles into the second burst's XFER -> rd_done completes that burst; no address update; FLUSH follows; next request is (0,256).
- vs_fall on the same cycle as rd_ack -> XFER entered; after rd_done, FLUSH and restart from address 0.
- rst pulsed mid-XFER, then a spurious rd_done -> all outputs at reset values; the rd_done is ignored; the next vs_fall starts at (0,256).
- With VGA_FETCH_UNDERRUN_CNT_EN: 5 cycles of lcd_request && fifo_empty -> underrun_cnt=5. Preload 16'hFFFE plus 3 underrun cycles -> 16'hFFFF. Next FLUSH -> 0.

Source files
------------

// File: rtl/vga_frame_fetch_sched_if.sv
// Burst read request channel between the frame fetch scheduler and the SDRAM read port.
interface vga_frame_fetch_sched_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              rd_req;
    logic              rd_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [8:0]        rd_len;
    logic              rd_done;

    modport master (
        output rd_req,
        output rd_addr,
        output rd_len,
        input  rd_ack,
        input  rd_done
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  rd_len,
        output rd_ack,
        output rd_done
    );
endinterface

// File: rtl/vga_frame_fetch_sched.sv
// Fetches one frame of pixels per display frame as SDRAM bursts, restarting at every vsync.
// Optional underrun counter enabled by defining VGA_FETCH_UNDERRUN_CNT_EN.
module vga_frame_fetch_sched #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned FRAME_BASE  = 0,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned LVL_W       = 10,
    parameter int unsigned FILL_THRESH = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lcd_framesync,
    input  logic [LVL_W-1:0]        fifo_wrusedw,
    vga_frame_fetch_sched_if.master bus,
    output logic                    fifo_aclr,
    output logic                    frame_active
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    ,
    input  logic                    lcd_request,
    input  logic                    fifo_empty,
    output logic [15:0]             underrun_cnt
`endif
);

    localparam int unsigned LEN_W    = 9;
    localparam int unsigned WL_W_RAW = $clog2(FRAME_WORDS + 1);
    // Wide enough to hold both the frame size and a full burst length
    localparam int unsigned WL_W     = (WL_W_RAW > 10) ? WL_W_RAW : 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH1,
        S_FLUSH2,
        S_CHECK,
        S_REQ,
        S_XFER
    } state_t;

    state_t            state, state_nxt;
    logic              framesync_d;
    logic              rd_req_q, rd_req_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [WL_W-1:0]   wl_q, wl_nxt;
    logic              pend_q, pend_nxt;
    logic              active_q, active_nxt;
    logic              aclr_q, aclr_nxt;

    logic              vs_fall;
    logic              level_ok;
    logic [LEN_W-1:0]  len_sel;

    assign vs_fall  = framesync_d & ~lcd_framesync;
    assign level_ok = 32'(fifo_wrusedw) <= FILL_THRESH;
    assign len_sel  = (wl_q >= WL_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(wl_q);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            framesync_d <= 1'b1;
            rd_req_q    <= 1'b0;
            addr_q      <= ADDR_W'(FRAME_BASE);
            len_q       <= '0;
            wl_q        <= '0;
            pend_q      <= 1'b0;
            active_q    <= 1'b0;
            aclr_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            framesync_d <= lcd_framesync;
            rd_req_q    <= rd_req_nxt;
            addr_q      <= addr_nxt;
            len_q       <= len_nxt;
            wl_q        <= wl_nxt;
            pend_q      <= pend_nxt;
            active_q    <= active_nxt;
            aclr_q      <= aclr_nxt;
        end
    end

    // Next-state and next-output logic; outputs are registered from the next state
    always_comb begin
        state_nxt  = state;
        rd_req_nxt = rd_req_q;
        addr_nxt   = addr_q;
        len_nxt    = len_q;
        wl_nxt     = wl_q;
        pend_nxt   = pend_q;
        active_nxt = active_q;

        case (state)
            S_IDLE: begin
                if (vs_fall) state_nxt = S_FLUSH1;
            end
            S_FLUSH1: begin
                addr_nxt  = ADDR_W'(FRAME_BASE);
                wl_nxt    = WL_W'(FRAME_WORDS);
                state_nxt = S_FLUSH2;
            end
            S_FLUSH2: begin
                active_nxt = 1'b1;
                state_nxt  = S_CHECK;
            end
            S_CHECK: begin
                if (vs_fall) begin
                    state_nxt = S_FLUSH1;
                end else if (wl_q == '0) begin
                    active_nxt = 1'b0;
                    state_nxt  = S_IDLE;
                end else if (level_ok) begin
                    len_nxt    = len_sel;
                    rd_req_nxt = 1'b1;
                    state_nxt  = S_REQ;
                end
            end
            S_REQ: begin
                // An ack in the same cycle as vsync wins; the restart is deferred to rd_done
                if (bus.rd_ack) begin
                    rd_req_nxt = 1'b0;
                    pend_nxt   = vs_fall;
                    state_nxt  = S_XFER;
                end else if (vs_fall) begin
                    rd_req_nxt = 1'b0;
                    state_nxt  = S_FLUSH1;
                end
            end
            S_XFER: begin
                if (bus.rd_done) begin
                    pend_nxt = 1'b0;
                    if (pend_q || vs_fall) begin
                        state_nxt = S_FLUSH1;
                    end else begin
                        addr_nxt  = addr_q + ADDR_W'(len_q);
                        wl_nxt    = wl_q - WL_W'(len_q);
                        state_nxt = S_CHECK;
                    end
                end else if (vs_fall) begin
                    pend_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        aclr_nxt = (state_nxt == S_FLUSH1) || (state_nxt == S_FLUSH2);
    end

    assign bus.rd_req   = rd_req_q;
    assign bus.rd_addr  = addr_q;
    assign bus.rd_len   = len_q;
    assign fifo_aclr    = aclr_q;
    assign frame_active = active_q;

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    // Saturating count of pixel requests that found the FIFO empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (state == S_FLUSH1) begin
            underrun_cnt <= '0;
        end else if (lcd_request && fifo_empty && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_fetch_sched.sv
// Scoreboard bench for vga_frame_fetch_sched: expected bursts are queued per frame start.
module tb_vga_frame_fetch_sched;

    localparam int unsigned ADDR_W      = 24;
    localparam int unsigned FRAME_BASE  = 0;
    localparam int unsigned FRAME_WORDS = 600;
    localparam int unsigned BURST_LEN   = 256;
    localparam int unsigned LVL_W       = 10;
    localparam int unsigned FILL_THRESH = 512;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [8:0]        len;
    } burst_t;

    logic             clk;
    logic             rst;
    logic             lcd_framesync;
    logic [LVL_W-1:0] fifo_wrusedw;
    logic             fifo_aclr;
    logic             frame_active;
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    logic             lcd_request;
    logic             fifo_empty;
    logic [15:0]      underrun_cnt;
`endif

    int unsigned n_checks;
    int unsigned n_errors;
    burst_t      exp_q[$];

    vga_frame_fetch_sched_if #(.ADDR_W(ADDR_W)) bus ();

    vga_frame_fetch_sched #(
        .ADDR_W      (ADDR_W),
        .FRAME_BASE  (FRAME_BASE),
        .FRAME_WORDS (FRAME_WORDS),
        .BURST_LEN   (BURST_LEN),
        .LVL_W       (LVL_W),
        .FILL_THRESH (FILL_THRESH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lcd_framesync (lcd_framesync),
        .fifo_wrusedw  (fifo_wrusedw),
        .bus           (bus.master),
        .fifo_aclr     (fifo_aclr),
        .frame_active  (frame_active)
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        ,
        .lcd_request   (lcd_request),
        .fifo_empty    (fifo_empty),
        .underrun_cnt  (underrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected burst list for one full frame
    task automatic load_frame();
        int unsigned rem;
        int unsigned a;
        int unsigned l;
        burst_t      b;
        exp_q.delete();
        rem = FRAME_WORDS;
        a   = FRAME_BASE;
        while (rem > 0) begin
            l      = (rem > BURST_LEN) ? BURST_LEN : rem;
            b.addr = ADDR_W'(a);
            b.len  = 9'(l);
            exp_q.push_back(b);
            a   = a + l;
            rem = rem - l;
        end
    endtask

    task automatic pop_exp(output burst_t b);
        if (exp_q.size() == 0) begin
            chk_val("sb_empty", 32'(0), 32'(1));
            b = '0;
        end else begin
            b = exp_q.pop_front();
        end
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!bus.rd_req && n < budget) begin
            tick();
            n++;
        end
        if (!bus.rd_req) chk_val("req_timeout", 32'(0), 32'(1));
    endtask

    // Called in the first FLUSH cycle; ends in the CHECK cycle
    task automatic flush_seq();
        chk_val("aclr_c1", 32'(fifo_aclr), 32'(1));
        tick();
        chk_val("aclr_c2", 32'(fifo_aclr), 32'(1));
        tick();
        chk_val("aclr_end", 32'(fifo_aclr), 32'(0));
        chk_val("active_on", 32'(frame_active), 32'(1));
        chk_val("req_lo_check", 32'(bus.rd_req), 32'(0));
    endtask

    task automatic start_frame();
        lcd_framesync = 1'b0;
        tick();
        lcd_framesync = 1'b1;
        load_frame();
        flush_seq();
    endtask

    // Serve one request: ack 2 cycles later, done 10 cycles after ack; optional vsync injection
    task automatic serve(input int vs_at, input bit vs_with_ack);
        burst_t e;
        bit     restart;
        restart = (vs_at >= 0) || vs_with_ack;
        pop_exp(e);
        chk_val("req_hi", 32'(bus.rd_req), 32'(1));
        chk_val("req_addr", 32'(bus.rd_addr), 32'(e.addr));
        chk_val("req_len", 32'(bus.rd_len), 32'(e.len));
        tick();
        tick();
        chk_val("addr_stable", 32'(bus.rd_addr), 32'(e.addr));
        bus.rd_ack = 1'b1;
        if (vs_with_ack) lcd_framesync = 1'b0;
        tick();
        bus.rd_ack    = 1'b0;
        lcd_framesync = 1'b1;
        chk_val("req_drop", 32'(bus.rd_req), 32'(0));
        for (int i = 0; i < 10; i++) begin
            lcd_framesync = (i == vs_at) ? 1'b0 : 1'b1;
            tick();
        end
        lcd_framesync = 1'b1;
        bus.rd_done   = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        if (restart) begin
            chk_val("restart_aclr", 32'(fifo_aclr), 32'(1));
            chk_val("no_addr_upd", 32'(bus.rd_addr), 32'(e.addr));
            load_frame();
        end else begin
            chk_val("no_aclr", 32'(fifo_aclr), 32'(0));
        end
    endtask

    initial begin
        int     seen;
        burst_t e;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        lcd_framesync = 1'b1;
        fifo_wrusedw  = '0;
        bus.rd_ack    = 1'b0;
        bus.rd_done   = 1'b0;
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        lcd_request = 1'b0;
        fifo_empty  = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_val("rst_req", 32'(bus.rd_req), 32'(0));
        chk_val("rst_addr", 32'(bus.rd_addr), 32'(FRAME_BASE));
        chk_val("rst_len", 32'(bus.rd_len), 32'(0));
        chk_val("rst_aclr", 32'(fifo_aclr), 32'(0));
        chk_val("rst_active", 32'(frame_active), 32'(0));

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        lcd_request = 1'b1;
        fifo_empty  = 1'b1;
        repeat (5) tick();
        lcd_request = 1'b0;
        chk_val("urun_5", 32'(underrun_cnt), 32'(5));
        lcd_request = 1'b1;
        repeat (65529) tick();
        chk_val("urun_fffe", 32'(underrun_cnt), 32'h0000FFFE);
        repeat (3) tick();
        chk_val("urun_sat", 32'(underrun_cnt), 32'h0000FFFF);
        lcd_request = 1'b0;
        fifo_empty  = 1'b0;
`endif

        // Full frame with low FIFO level
        start_frame();
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        chk_val("urun_clr", 32'(underrun_cnt), 32'(0));
`endif
        tick();
        serve(-1, 1'b0);
        wait_req(8);
        serve(-1, 1'b0);
        wait_req(8);
        serve(-1, 1'b0);
        chk_val("sb_drained", 32'(exp_q.size()), 32'(0));
        tick();
        chk_val("active_off", 32'(frame_active), 32'(0));
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rd_req) seen++;
            tick();
        end
        chk_val("no_req_idle", 32'(seen), 32'(0));

        // Level above threshold holds off requests
        fifo_wrusedw = LVL_W'(FILL_THRESH + 1);
        start_frame();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rd_req) seen++;
        end
        chk_val("thresh_hold", 32'(seen), 32'(0));
        fifo_wrusedw = LVL_W'(FILL_THRESH);
        tick();
        serve(-1, 1'b0);
        fifo_wrusedw = '0;

        // vsync during the second burst's transfer
        wait_req(8);
        serve(3, 1'b0);
        flush_seq();
        tick();

        // vsync coincident with rd_ack
        serve(-1, 1'b1);
        flush_seq();
        tick();

        // Reset in the middle of a transfer
        pop_exp(e);
        chk_val("r_req_hi", 32'(bus.rd_req), 32'(1));
        chk_val("r_req_addr", 32'(bus.rd_addr), 32'(e.addr));
        tick();
        tick();
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk_val("arst_req", 32'(bus.rd_req), 32'(0));
        chk_val("arst_addr", 32'(bus.rd_addr), 32'(FRAME_BASE));
        chk_val("arst_len", 32'(bus.rd_len), 32'(0));
        chk_val("arst_aclr", 32'(fifo_aclr), 32'(0));
        chk_val("arst_active", 32'(frame_active), 32'(0));
        tick();
        rst = 1'b0;
        exp_q.delete();
        bus.rd_done = 1'b1;
        bus.rd_ack  = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        bus.rd_ack  = 1'b0;
        repeat (3) tick();
        chk_val("late_req", 32'(bus.rd_req), 32'(0));
        chk_val("late_addr", 32'(bus.rd_addr), 32'(FRAME_BASE));
        chk_val("late_aclr", 32'(fifo_aclr), 32'(0));
        chk_val("late_active", 32'(frame_active), 32'(0));
        start_frame();
        tick();
        serve(-1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
